// File: rtl/axi4_full_master.sv
// Single-outstanding AXI4 burst initiator: one command becomes AW/W/B or AR/R, then a done pulse.
// Defining AXI4_FULL_MASTER_ID_CHECK_EN adds bid/rid/rlast checking and a sticky id_error output.
module axi4_full_master #(
  parameter int G_ADDR_WIDTH = 6,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_ID_WIDTH   = 2,
  parameter int G_ID         = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [G_DATA_WIDTH-1:0] wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [G_DATA_WIDTH-1:0] rd_data,
  output logic                    done,
  output logic [1:0]              done_resp,
`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
  output logic                    id_error,
`endif
  output logic [2:0]              dbg_state,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [G_ID_WIDTH-1:0]   m_awid,
  output logic [G_ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [1:0]              m_awlock,
  output logic [3:0]              m_awcache,
  output logic [2:0]              m_awprot,
  output logic [3:0]              m_awqos,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [G_ID_WIDTH-1:0]   m_wid,
  output logic [G_DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]              m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [G_ID_WIDTH-1:0]   m_bid,
  input  logic [1:0]              m_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [G_ID_WIDTH-1:0]   m_arid,
  output logic [G_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic [1:0]              m_arlock,
  output logic [3:0]              m_arcache,
  output logic [2:0]              m_arprot,
  output logic [3:0]              m_arqos,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [G_ID_WIDTH-1:0]   m_rid,
  input  logic [G_DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast
);
  // Handshake rule on every port: a transfer occurs at a posedge where valid && ready;
  // valid never waits on ready, and address/len/data hold until that transfer.
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  localparam logic [G_ID_WIDTH-1:0] C_ID   = G_ID_WIDTH'(G_ID);
  localparam logic [2:0]            C_SIZE = 3'($clog2(G_DATA_WIDTH / 8));

  state_t                  state_q, state_d;
  logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d, count_q, count_d;
  logic [1:0]              resp_q, resp_d;
  logic                    done_q, done_d;
  logic [1:0]              done_resp_q, done_resp_d;
  logic [1:0]              r_acc, b_resp;

  assign m_awid = C_ID;  assign m_arid = C_ID;  assign m_wid = C_ID;
  assign m_awaddr = addr_q;  assign m_araddr = addr_q;
  assign m_awlen = len_q;    assign m_arlen = len_q;
  assign m_awsize = C_SIZE;  assign m_arsize = C_SIZE;
  assign m_awburst = 2'b01;  assign m_arburst = 2'b01;
  assign m_awlock = '0;  assign m_awcache = '0;  assign m_awprot = '0;  assign m_awqos = '0;
  assign m_arlock = '0;  assign m_arcache = '0;  assign m_arprot = '0;  assign m_arqos = '0;
  assign m_wstrb = 4'hF;
  assign m_wdata = wr_data;
  assign rd_data = m_rdata;
  assign done = done_q;
  assign done_resp = done_resp_q;
  assign dbg_state = state_q;

  always_comb begin
    r_acc  = (m_rresp > resp_q) ? m_rresp : resp_q;
    b_resp = m_bresp;
`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
    if (m_rid != C_ID) r_acc = 2'b10;
    if (m_bid != C_ID) b_resp = 2'b10;
`endif
  end

  always_comb begin
    state_d = state_q;  addr_d = addr_q;  len_d = len_q;
    count_d = count_q;  resp_d = resp_q;
    done_d = 1'b0;  done_resp_d = 2'b00;
    cmd_ready = 1'b0;  m_awvalid = 1'b0;  m_arvalid = 1'b0;
    m_wvalid = 1'b0;  wr_ready = 1'b0;  m_wlast = 1'b0;
    m_bready = 1'b0;  m_rready = 1'b0;  rd_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) begin
          addr_d = cmd_addr;  len_d = cmd_len;
          count_d = 8'd0;  resp_d = 2'b00;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = S_W;
      end
      S_W: begin
        m_wvalid = wr_valid;
        wr_ready = m_wready;
        m_wlast  = (count_q == len_q);
        if (wr_valid && m_wready) begin
          count_d = count_q + 8'd1;
          if (count_q == len_q) state_d = S_B;
        end
      end
      S_B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          done_d = 1'b1;  done_resp_d = b_resp;  state_d = S_IDLE;
        end
      end
      S_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_R;
      end
      S_R: begin
        m_rready = rd_ready;
        rd_valid = m_rvalid;
        // End of burst comes from our own beat count; rlast is not trusted here.
        if (m_rvalid && rd_ready) begin
          resp_d  = r_acc;
          count_d = count_q + 8'd1;
          if (count_q == len_q) begin
            done_d = 1'b1;  done_resp_d = r_acc;  state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  addr_q <= '0;  len_q <= '0;
      count_q <= '0;  resp_q <= '0;  done_q <= 1'b0;  done_resp_q <= '0;
    end else begin
      state_q <= state_d;  addr_q <= addr_d;  len_q <= len_d;
      count_q <= count_d;  resp_q <= resp_d;  done_q <= done_d;  done_resp_q <= done_resp_d;
    end
  end

`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
  logic id_error_q, id_err_set;
  assign id_err_set =
    ((state_q == S_B) && m_bvalid && (m_bid != C_ID)) ||
    ((state_q == S_R) && m_rvalid && rd_ready &&
     ((m_rid != C_ID) || ((count_q == len_q) && !m_rlast)));
  assign id_error = id_error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) id_error_q <= 1'b0;
    else       id_error_q <= id_error_q | id_err_set;
  end
`else
  logic unused_id_in;
  assign unused_id_in = ^{m_bid, m_rid, m_rlast};
`endif
endmodule

// File: tb/tb_axi4_full_master.sv
// Bench for axi4_full_master: a small AXI4 memory slave plus scoreboard queues for
// W beats, read data and done responses.
`timescale 1ns/1ps
module tb_axi4_full_master;
  localparam int AW = 6, DW = 32, IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic wr_valid = 0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid, rd_ready = 1;
  logic [DW-1:0] rd_data;
  logic done;
  logic [1:0] done_resp;
  logic [2:0] dbg_state;
`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
  logic id_error;
`endif
  logic m_awvalid, m_awready = 1;
  logic [IW-1:0] m_awid, m_arid, m_wid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0] m_awburst, m_arburst, m_awlock, m_arlock;
  logic [3:0] m_awcache, m_arcache, m_awqos, m_arqos, m_wstrb;
  logic m_wvalid, m_wready = 1, m_wlast;
  logic [DW-1:0] m_wdata;
  logic m_bvalid = 0, m_bready;
  logic [IW-1:0] m_bid = '0, m_rid = '0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic m_arvalid, m_arready = 1;
  logic m_rvalid = 0, m_rready, m_rlast = 0;
  logic [DW-1:0] m_rdata = '0;

  axi4_full_master #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_ID_WIDTH(IW), .G_ID(0)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .done_resp(done_resp),
`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
    .id_error(id_error),
`endif
    .dbg_state(dbg_state),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  // Clock: inputs change on negedge, everything is sampled 1 ns before posedge.
  always #5 clock = ~clock;

  // Scoreboard state
  logic [DW-1:0] w_exp_q[$];
  logic [DW-1:0] rd_exp_q[$];
  logic [1:0]    resp_exp_q[$];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] wdata_buf[256];
  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, r_hs = 0, w_seen = 0, cur_len = 0;
  logic [AW-1:0] exp_addr = '0;
  logic done_due = 0;

  // Slave model state
  logic [DW-1:0] s_mem[16];
  logic [AW-1:0] s_waddr = '0, s_raddr = '0;
  logic [7:0] s_wbeat = '0, s_rbeat = '0, s_rlen = '0;
  logic s_bpend = 0, s_ractive = 0;
  logic [1:0] slv_resp = 2'b00;
  logic [IW-1:0] slv_rid = '0;

  initial begin : slave_and_monitor
    logic due;
    for (int i = 0; i < 16; i++) begin s_mem[i] = '0; ref_mem[i] = '0; end
    forever begin
      @(negedge clock);
      m_bvalid = s_bpend;  m_bresp = slv_resp;  m_bid = slv_rid;
      m_rvalid = s_ractive;  m_rresp = slv_resp;  m_rid = slv_rid;
      m_rdata = s_mem[s_raddr[5:2] + s_rbeat[3:0]];
      m_rlast = s_ractive && (s_rbeat == s_rlen);
      #4;
      if (reset) begin
        s_bpend = 0;  s_ractive = 0;  done_due = 0;
      end else begin
        due = done_due;  done_due = 0;
        if (due || done) begin
          n_cmp++;
          if (done !== due) begin n_err++; $display("FAIL done_pulse: got %0b expected %0b", done, due); end
          if (done) begin
            done_cnt++;
            n_cmp++;
            if (resp_exp_q.size() == 0) begin n_err++; $display("FAIL done_resp: got %0h expected none", done_resp); end
            else begin
              logic [1:0] er;
              er = resp_exp_q.pop_front();
              if (done_resp !== er) begin n_err++; $display("FAIL done_resp: got %0h expected %0h", done_resp, er); end
            end
            n_cmp++;
            if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_at_done: got %0b expected 1", cmd_ready); end
          end
        end
        if (m_awvalid && m_awready) begin
          s_waddr = m_awaddr;  s_wbeat = '0;
          n_cmp++;
          if (m_awaddr !== exp_addr || m_awlen !== 8'(cur_len) || m_awsize !== 3'd2 || m_awburst !== 2'b01) begin
            n_err++; $display("FAIL aw_fields: got addr %0h len %0d size %0d burst %0d expected addr %0h len %0d size 2 burst 1",
                              m_awaddr, m_awlen, m_awsize, m_awburst, exp_addr, cur_len);
          end
        end
        if (m_wvalid && m_wready) begin
          n_cmp++;
          if (w_exp_q.size() == 0) begin n_err++; $display("FAIL w_extra_beat: got %0h expected no beat", m_wdata); end
          else begin
            logic [DW-1:0] ew;
            ew = w_exp_q.pop_front();
            if (m_wdata !== ew) begin n_err++; $display("FAIL w_data: got %0h expected %0h", m_wdata, ew); end
          end
          n_cmp++;
          if (m_wlast !== (w_seen == cur_len)) begin
            n_err++; $display("FAIL w_last: beat %0d got %0b expected %0b", w_seen, m_wlast, (w_seen == cur_len));
          end
          w_seen++;
          s_mem[s_waddr[5:2] + s_wbeat[3:0]] = m_wdata;
          s_wbeat = s_wbeat + 8'd1;
          if (m_wlast) s_bpend = 1;
        end
        if (m_bvalid && m_bready) begin
          s_bpend = 0;  done_due = 1;
        end
        if (m_arvalid && m_arready) begin
          s_raddr = m_araddr;  s_rbeat = '0;  s_rlen = m_arlen;  s_ractive = 1;
          n_cmp++;
          if (m_araddr !== exp_addr || m_arlen !== 8'(cur_len) || m_arburst !== 2'b01) begin
            n_err++; $display("FAIL ar_fields: got addr %0h len %0d expected addr %0h len %0d", m_araddr, m_arlen, exp_addr, cur_len);
          end
        end
        if (m_rvalid && m_rready) begin
          n_cmp++;
          if (rd_exp_q.size() == 0) begin n_err++; $display("FAIL rd_extra_beat: got %0h expected no beat", rd_data); end
          else begin
            logic [DW-1:0] er2;
            er2 = rd_exp_q.pop_front();
            if (rd_data !== er2 || rd_valid !== 1'b1) begin
              n_err++; $display("FAIL rd_data: got %0h valid %0b expected %0h valid 1", rd_data, rd_valid, er2);
            end
          end
          r_hs++;
          if (r_hs == cur_len + 1) done_due = 1;
          if (s_rbeat == s_rlen) s_ractive = 0;
          else s_rbeat = s_rbeat + 8'd1;
        end
      end
    end
  end

  // Driver tasks
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] resp, output logic done_at_accept);
    int t;
    @(negedge clock);
    cmd_valid = 1;  cmd_write = wr;  cmd_addr = addr;  cmd_len = 8'(len);
    cur_len = len;  exp_addr = addr;  w_seen = 0;  r_hs = 0;
    resp_exp_q.push_back(resp);
    if (!wr) for (int i = 0; i <= len; i++) rd_exp_q.push_back(ref_mem[addr[5:2] + 4'(i)]);
    t = 0;
    #4;
    while (!cmd_ready && t < 50) begin @(negedge clock); #4; t++; end
    done_at_accept = done;
    n_cmp++;
    if (!cmd_ready) begin n_err++; $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1"); end
    @(negedge clock);
    cmd_valid = 0;
    #4;
    n_cmp++;
    if ((wr ? m_awvalid : m_arvalid) !== 1'b1) begin
      n_err++; $display("FAIL addr_valid_latency: got %0b expected 1", wr ? m_awvalid : m_arvalid);
    end
  endtask

  task automatic drive_wr(input int beats_m1, input bit toggle, input logic [AW-1:0] addr);
    int t;
    for (int i = 0; i <= beats_m1; i++) begin
      if (toggle) begin
        @(negedge clock);
        wr_valid = 0;
        #4;
        n_cmp++;
        if (m_wvalid !== 1'b0) begin n_err++; $display("FAIL wvalid_gap: got %0b expected 0", m_wvalid); end
      end
      @(negedge clock);
      wr_valid = 1;  wr_data = wdata_buf[i];
      ref_mem[addr[5:2] + 4'(i)] = wdata_buf[i];
      w_exp_q.push_back(wdata_buf[i]);
      t = 0;
      #4;
      while (!wr_ready && t < 50) begin @(negedge clock); #4; t++; end
      if (!wr_ready) begin
        n_cmp++; n_err++; $display("FAIL wr_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(negedge clock);
    wr_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 1200) begin @(posedge clock); t++; end
    n_cmp++;
    if (done_cnt < target) begin n_err++; $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target); end
  endtask

  task automatic check_rhs(input int exp_hs);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (r_hs !== exp_hs) begin n_err++; $display("FAIL r_handshakes: got %0d expected %0d", r_hs, exp_hs); end
  endtask

  // Test scenarios
  task automatic test_reset();
    @(negedge clock);
    #1;
    n_cmp++;
    if ({m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready, wr_ready, rd_valid, done, cmd_ready} !== 10'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000000000",
        {m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready, wr_ready, rd_valid, done, cmd_ready});
    end
    n_cmp++;
    if (m_awsize !== 3'd2 || m_arsize !== 3'd2 || m_awburst !== 2'b01 || m_wstrb !== 4'hF ||
        m_awid !== 2'd0 || m_wid !== 2'd0 || m_arid !== 2'd0 || {m_awlock, m_awcache, m_awprot, m_awqos} !== 13'd0) begin
      n_err++; $display("FAIL constants: got size %0d burst %0d strb %0h ids %0d/%0d/%0d expected 2 1 f 0/0/0",
                        m_awsize, m_awburst, m_wstrb, m_awid, m_wid, m_arid);
    end
    @(negedge clock);
    reset = 0;
    #4;
    n_cmp++;
    if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
      n_err++; $display("FAIL post_reset_idle: got ready %0b state %0d expected ready 1 state 0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_write_burst();
    int d0;  logic dac;
    for (int i = 0; i < 4; i++) wdata_buf[i] = 32'hA0 + 32'(i);
    d0 = done_cnt;
    issue_cmd(1'b1, 6'h10, 3, 2'b00, dac);
    drive_wr(3, 1'b0, 6'h10);
    wait_done(d0 + 1);
  endtask

  task automatic test_read_burst();
    int d0;  logic dac;
    rd_ready = 1;
    d0 = done_cnt;
    issue_cmd(1'b0, 6'h10, 3, 2'b00, dac);
    wait_done(d0 + 1);
    check_rhs(4);
  endtask

  task automatic test_write_toggle();
    int d0;  logic dac;
    wdata_buf[0] = $urandom;
    d0 = done_cnt;
    issue_cmd(1'b1, 6'h04, 0, 2'b00, dac);
    drive_wr(0, 1'b1, 6'h04);
    wait_done(d0 + 1);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (w_seen !== 1) begin n_err++; $display("FAIL toggle_beats: got %0d expected 1", w_seen); end
  endtask

  task automatic test_read_stall();
    int d0, t, hs;  logic dac;
    rd_ready = 1;
    d0 = done_cnt;
    issue_cmd(1'b0, 6'h10, 3, 2'b00, dac);
    t = 0;
    while (r_hs < 2 && t < 50) begin @(posedge clock); t++; end
    @(negedge clock);
    rd_ready = 0;
    hs = r_hs;
    for (int c = 0; c < 5; c++) begin
      #4;
      n_cmp++;
      if (m_rready !== 1'b0 || r_hs !== hs) begin
        n_err++; $display("FAIL read_stall: got rready %0b beats %0d expected rready 0 beats %0d", m_rready, r_hs, hs);
      end
      @(negedge clock);
    end
    rd_ready = 1;
    wait_done(d0 + 1);
    check_rhs(4);
  endtask

  task automatic test_reset_mid_write();
    logic dac;
    for (int i = 0; i < 4; i++) wdata_buf[i] = 32'hC0 + 32'(i);
    issue_cmd(1'b1, 6'h20, 3, 2'b00, dac);
    drive_wr(1, 1'b0, 6'h20);
    wr_valid = 1;  wr_data = 32'hC2;
    #1 reset = 1;
    #1;
    n_cmp++;
    if ({m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready, wr_ready, rd_valid, done, cmd_ready} !== 10'b0) begin
      n_err++; $display("FAIL async_reset: got %b expected 0000000000",
        {m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready, wr_ready, rd_valid, done, cmd_ready});
    end
    wr_valid = 0;
    w_exp_q.delete();  rd_exp_q.delete();  resp_exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 0;
    #4;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int d0;  logic dac;
    wdata_buf[0] = 32'h1111_0000;  wdata_buf[1] = 32'h2222_0001;
    d0 = done_cnt;
    issue_cmd(1'b1, 6'h00, 1, 2'b00, dac);
    drive_wr(1, 1'b0, 6'h00);
    issue_cmd(1'b0, 6'h00, 1, 2'b00, dac);
    n_cmp++;
    if (dac !== 1'b1) begin n_err++; $display("FAIL back_to_back_accept: got done %0b at accept expected 1", dac); end
    wait_done(d0 + 2);
    check_rhs(2);
  endtask

  task automatic test_len255_wrap();
    int d0;  logic dac;
    for (int i = 0; i < 256; i++) wdata_buf[i] = $urandom_range(32'h7FFF_FFFF, 0);
    d0 = done_cnt;
    issue_cmd(1'b1, 6'h00, 255, 2'b00, dac);
    drive_wr(255, 1'b0, 6'h00);
    wait_done(d0 + 1);
    issue_cmd(1'b0, 6'h00, 255, 2'b00, dac);
    wait_done(d0 + 2);
    check_rhs(256);
  endtask

  task automatic test_bresp_error();
    int d0;  logic dac;
    slv_resp = 2'b10;
    wdata_buf[0] = 32'hDEAD_BEEF;
    d0 = done_cnt;
    issue_cmd(1'b1, 6'h0C, 0, 2'b10, dac);
    drive_wr(0, 1'b0, 6'h0C);
    wait_done(d0 + 1);
    slv_resp = 2'b00;
  endtask

`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
  task automatic test_id_check();
    int d0;  logic dac;
    slv_rid = 2'd1;
    d0 = done_cnt;
    issue_cmd(1'b0, 6'h10, 1, 2'b10, dac);
    wait_done(d0 + 1);
    n_cmp++;
    if (id_error !== 1'b1) begin n_err++; $display("FAIL id_error_set: got %0b expected 1", id_error); end
    slv_rid = 2'd0;
    wdata_buf[0] = 32'h5A5A_5A5A;
    issue_cmd(1'b1, 6'h08, 0, 2'b00, dac);
    drive_wr(0, 1'b0, 6'h08);
    wait_done(d0 + 2);
    n_cmp++;
    if (id_error !== 1'b1) begin n_err++; $display("FAIL id_error_sticky: got %0b expected 1", id_error); end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_write_burst();
    test_read_burst();
    test_write_toggle();
    test_read_stall();
    test_reset_mid_write();
    test_back_to_back();
    test_len255_wrap();
    test_bresp_error();
`ifdef AXI4_FULL_MASTER_ID_CHECK_EN
    test_id_check();
`endif
    repeat (4) @(negedge clock);
    n_cmp++;
    if (w_exp_q.size() != 0 || rd_exp_q.size() != 0 || resp_exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover_expectations: got w %0d rd %0d resp %0d expected 0 0 0",
                        w_exp_q.size(), rd_exp_q.size(), resp_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
